// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : frame_loader
// Description : Turns the SPI receiver byte stream into image frames in a
//               double-buffered (ping-pong) frame RAM. A start-of-frame byte
//               opens a frame. The next imgWidth*imgHeight bytes are written
//               to consecutive addresses. The finished bank is then handed to
//               the edge-detection core through a frameReady/frameRelease
//               handshake.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               byteIn/byteValid         - received byte stream
//               csActive                 - SPI chip select level
//               memWrite{Addr,Data,En,Bank} - frame RAM write port
//               readBank/frameReady      - completed frame for the core
//               frameRelease             - core is done with readBank
//               frameCount               - committed frames (wrapping)
//               abortErr/overrunErr      - abort pulse / sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module frame_loader #(
    parameter int          imgWidth  = 64,
    parameter int          imgHeight = 48,
    parameter logic [7:0]  sofByte   = 8'hA5,
    parameter int          addrBits  = $clog2(imgWidth*imgHeight)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byteIn,
    input  logic                byteValid,
    input  logic                csActive,
    output logic [addrBits-1:0] memWriteAddr,
    output logic [7:0]          memWriteData,
    output logic                memWriteEn,
    output logic                memWriteBank,
    output logic                readBank,
    output logic                frameReady,
    input  logic                frameRelease,
    output logic [7:0]          frameCount,
    output logic                abortErr,
    output logic                overrunErr
);

    localparam logic [addrBits-1:0] c_LAST_ADDR = addrBits'(imgWidth*imgHeight - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [addrBits-1:0] cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [addrBits-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                bank_q, bank_d;
    logic                ready_q, ready_d;
    logic [7:0]          count_q, count_d;
    logic                abort_q, abort_d;
    logic                overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            bank_q    <= 1'b0;
            ready_q   <= 1'b0;
            count_q   <= 8'd0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bank_q    <= bank_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bank_d    = bank_q;
        ready_d   = ready_q;
        count_d   = count_q;
        abort_d   = 1'b0;
        overrun_d = overrun_q;

        // A release frees the read bank; a commit in the same cycle (below)
        // overrides this and keeps frameReady set for the new frame.
        if (frameRelease && ready_q) begin
            ready_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (byteValid && (byteIn == sofByte)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end

            LOAD: begin
                if (byteValid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = byteIn;
                    if (cnt_q == c_LAST_ADDR) begin
                        // Completing the frame takes priority over a
                        // simultaneous chip-select drop.
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!csActive) begin
                            state_d = IDLE;
                            abort_d = 1'b1;
                        end
                    end
                end else if (!csActive) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
            end

            COMMIT: begin
                if (!ready_q || frameRelease) begin
                    bank_d  = ~bank_q;
                    ready_d = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = IDLE;
                end else if (byteValid) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign memWriteAddr = wr_addr_q;
    assign memWriteData = wr_data_q;
    assign memWriteEn   = wr_en_q;
    assign memWriteBank = bank_q;
    assign readBank     = ~bank_q;
    assign frameReady   = ready_q;
    assign frameCount   = count_q;
    assign abortErr     = abort_q;
    assign overrunErr   = overrun_q;

endmodule
`default_nettype wire

// File: doc/frame_loader.md
# frame_loader

Sits directly downstream of the SPI byte receiver and turns its received byte stream into image frames in the edge-detection frame RAM. It waits for a start-of-frame byte, then writes `imgWidth*imgHeight` pixel bytes to consecutive RAM addresses in row-major order. It ping-pongs between two RAM banks so the edge-detection core can read one complete frame while the next one loads. A ready/release handshake with the core governs each bank swap.

## Interface
Parameters:
- imgWidth, 64, pixels per row (≥2)
- imgHeight, 48, rows per frame (≥2)
- sofByte, 8'hA5, start-of-frame command byte
- addrBits, $clog2(imgWidth*imgHeight), RAM address width within one bank

Ports:
- clk  input  1  system clock; one clock domain
- rst  input  1  synchronous, active-high reset
- byteIn  input  8  received byte, already synchronized to clk
- byteValid  input  1  one-cycle strobe; each cycle high = one byte
- csActive  input  1  SPI chip select active, synchronized, level
- memWriteAddr  output  addrBits  pixel address within bank
- memWriteData  output  8  pixel value
- memWriteEn  output  1  RAM write strobe
- memWriteBank  output  1  bank being written
- readBank  output  1  bank holding the completed frame; always ~memWriteBank
- frameReady  input/output: output  1  completed frame available in readBank
- frameRelease  input  1  one-cycle pulse from core: done with readBank
- frameCount  output  8  committed frames, wraps 255→0
- abortErr  output  1  one-cycle pulse: frame aborted by csActive low
- overrunErr  output  1  sticky: byte dropped while blocked in COMMIT

## Operation
- States: IDLE, LOAD, COMMIT.
- IDLE:
  - A byteValid with byteIn==sofByte moves to LOAD and clears the pixel address counter.
  - All other bytes are ignored and produce no error.
- LOAD:
  - Each byteValid registers memWriteData=byteIn and memWriteAddr=current counter, and pulses memWriteEn.
  - The counter then increments. A linear counter is used, with no multiply.
  - In LOAD, sofByte is treated as ordinary pixel data.
  - The byte at address imgWidth*imgHeight-1 is written and the state moves to COMMIT.
  - csActive low in any LOAD cycle without byteValid: move to IDLE, pulse abortErr, keep bank unchanged. The partial frame is discarded.
  - csActive low in the same cycle as byteValid: the byte is written first, then abort.
- COMMIT:
  - If frameReady==0, or frameRelease is high this cycle: toggle memWriteBank, set frameReady=1, increment frameCount, move to IDLE.
  - Otherwise stay in COMMIT. Any byteValid here is dropped and sets overrunErr, which is cleared only by rst.
- frameRelease:
  - Clears frameReady when no commit occurs in the same cycle.
  - Ignored when frameReady==0.
  - Release and commit in the same cycle: frameReady stays 1, bank swaps.
- Reset values:
  - State IDLE.
  - memWriteEn=0, memWriteAddr=0, memWriteData=0, memWriteBank=0 (so readBank=1).
  - frameReady=0, frameCount=0, abortErr=0, overrunErr=0.
- rst mid-frame: all state returns to reset values in the next cycle. No memWriteEn occurs after the rst cycle.

## Timing
- byteValid in cycle N gives memWriteEn/addr/data valid in cycle N+1, for exactly one cycle.
- memWriteEn rate: at most one per cycle. Back-to-back byteValid is supported.
- Last pixel:
  - byteValid in cycle N → write in N+1.
  - State is COMMIT in N+1.
  - memWriteBank toggles and frameReady rises in N+2 if unblocked.
- Blocked COMMIT: frameRelease in cycle M → swap and frameReady held high in M+1. Earliest next SOF is accepted in M+1.
- Abort: csActive low in LOAD cycle N → abortErr high in N+1, state IDLE in N+1.
- The sofByte cycle produces no memWriteEn.

## Test plan
Use imgWidth=4, imgHeight=2 for all scenarios.
- Basic frame:
  - Stimulus: rst, then A5 followed by bytes 10..17 back-to-back.
  - Required: 8 writes at addr 0..7, data 10..17, bank 0.
  - Required: frameReady=1 two cycles after byte 17, memWriteBank=1, readBank=0, frameCount=1.
- Ignore junk:
  - Stimulus: bytes 00, 3C, FF in IDLE, then A5 and 8 pixels.
  - Required: no write before the A5, first write at addr 0. A5 sent inside LOAD is written as data.
- Ping-pong with release:
  - Stimulus: frame 1, frameRelease, frame 2.
  - Required: frame 2 is written to bank 1, then bank toggles back to 0 and frameCount=2.
- Blocked commit:
  - Stimulus: frame 1, then frame 2 without release, then 2 extra bytes.
  - Required: state holds in COMMIT, overrunErr=1, bank unchanged.
  - Then frameRelease: the next cycle swaps the bank, frameReady stays 1, frameCount=2.
- Abort:
  - Stimulus: A5 and 3 pixels, then csActive low.
  - Required: abortErr pulse one cycle later, bank unchanged, frameCount unchanged.
  - A following full frame restarts at addr 0.
- Reset mid-frame:
  - Stimulus: rst asserted after 5 pixels.
  - Required: no further memWriteEn, all outputs at reset values. A new frame loads normally into bank 0.
